// File: rtl/weapons_pkg.sv
// weapons_pkg: definitions shared by the weapons-path blocks.
//   MODE_ATTACK    ship mode encoding in which shots may be issued
//   fc_state_t     fire_control sequencer states
//   AMMO_W_DEFAULT default width of the ammo count and rate buses
package weapons_pkg;

  localparam int AMMO_W_DEFAULT = 9;

  localparam logic [3:0] MODE_ATTACK = 4'b0010;

  typedef enum logic [1:0] {
    FC_IDLE  = 2'd0,
    FC_SHOOT = 2'd1,
    FC_COOL  = 2'd2
  } fc_state_t;

endpackage

// File: rtl/fire_control_cooldown_timer.sv
// cooldown_timer: 8-bit load/decrement counter.
//   clk, rst  clock and asynchronous active-high reset
//   load      load count with load_val (has priority over decrementing)
//   load_val  value to load
//   done      count has reached zero
// The counter holds at zero once it gets there, so done stays asserted
// until the next load.
module cooldown_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign done = (count == 8'd0);

endmodule

// File: rtl/fire_control.sv
// fire_control: trigger-to-weapon sequencer.
// Turns the level trigger into one-cycle fire strobes with a latched
// per-shot rate, gated by attack mode, ammo sufficiency and a cooldown.
//   clk, rst     clock, asynchronous active-high reset
//   mode         ship mode (attack = MODE_ATTACK)
//   trigger      level trigger from the pilot console
//   burst_sel    1 = burst of BURST_LEN shots (burst builds only)
//   ammo         current ammo count from the weapons stage
//   rate         requested rounds per shot
//   fire         one-cycle shot strobe
//   fire_rate    rounds per shot, latched on an accepted press
//   busy         sequencer is in SHOOT or COOL
//   error        one-cycle pulse on a rejected press or aborted burst
//   shots_fired  wrapping count of issued shots
// Build option: define FIRE_CONTROL_BURST_EN to enable burst sequencing;
// without it burst_sel is ignored and every press yields at most one shot.
// Handshake: none; trigger is a level, a press is its rising edge, and
// presses seen while busy are dropped without error.
module fire_control
  import weapons_pkg::*;
#(
  parameter int AMMO_W    = weapons_pkg::AMMO_W_DEFAULT,
  parameter int COOLDOWN  = 8,
  parameter int BURST_LEN = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mode,
  input  logic              trigger,
  input  logic              burst_sel,
  input  logic [AMMO_W-1:0] ammo,
  input  logic [AMMO_W-1:0] rate,
  output logic              fire,
  output logic [AMMO_W-1:0] fire_rate,
  output logic              busy,
  output logic              error,
  output logic [7:0]        shots_fired
);

  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN - 1);

  fc_state_t         state, state_next;
  logic              trig_q;
  logic              press;
  logic [AMMO_W-1:0] eff_rate;
  logic              attack;
  logic              legal;
  logic              accept;
  logic              error_next;
  logic              timer_load;
  logic              timer_done;
  logic              has_more;

  // trig_q resets high so a trigger already held at reset release is
  // not mistaken for a fresh press.
  assign press    = trigger & ~trig_q;
  assign eff_rate = (rate == '0) ? AMMO_W'(1) : rate;
  assign attack   = (mode == MODE_ATTACK);
  assign legal    = attack && (ammo != '0) && (ammo >= eff_rate);

`ifdef FIRE_CONTROL_BURST_EN
  localparam logic [3:0] REMAIN_LOAD = 4'(BURST_LEN - 1);

  logic [3:0] remaining, remaining_next;

  assign has_more = (remaining != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) remaining <= 4'd0;
    else     remaining <= remaining_next;
  end
`else
  localparam int UNUSED_BURST_LEN = BURST_LEN;

  logic unused_burst_sel;

  assign unused_burst_sel = burst_sel;
  assign has_more         = 1'b0;
`endif

  cooldown_timer u_cooldown_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (COOL_LOAD),
    .done     (timer_done)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    error_next = 1'b0;
    timer_load = 1'b0;
`ifdef FIRE_CONTROL_BURST_EN
    remaining_next = remaining;
`endif
    case (state)
      FC_IDLE: begin
        if (press) begin
          if (legal) begin
            state_next = FC_SHOOT;
            accept     = 1'b1;
`ifdef FIRE_CONTROL_BURST_EN
            remaining_next = burst_sel ? REMAIN_LOAD : 4'd0;
`endif
          end else begin
            error_next = 1'b1;
          end
        end
      end
      FC_SHOOT: begin
        state_next = FC_COOL;
        timer_load = 1'b1;
      end
      FC_COOL: begin
        if (timer_done) begin
          if (has_more && legal) begin
            state_next = FC_SHOOT;
`ifdef FIRE_CONTROL_BURST_EN
            remaining_next = remaining - 4'd1;
`endif
          end else begin
            state_next = FC_IDLE;
            // Leaving attack mode ends a burst quietly; running out of
            // ammo while still in attack mode is reported.
            error_next = has_more && attack;
`ifdef FIRE_CONTROL_BURST_EN
            remaining_next = 4'd0;
`endif
          end
        end
      end
      default: state_next = FC_IDLE;
    endcase
  end

  // Outputs are registered from next-state decisions so each lands in the
  // cycle the sequencer actually occupies the corresponding state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FC_IDLE;
      trig_q      <= 1'b1;
      fire        <= 1'b0;
      fire_rate   <= '0;
      busy        <= 1'b0;
      error       <= 1'b0;
      shots_fired <= 8'd0;
    end else begin
      state  <= state_next;
      trig_q <= trigger;
      fire   <= (state_next == FC_SHOOT);
      busy   <= (state_next != FC_IDLE);
      error  <= error_next;
      if (accept) fire_rate <= eff_rate;
      if (state == FC_SHOOT) shots_fired <= shots_fired + 8'd1;
    end
  end

endmodule

// File: tb/tb_fire_control.sv
module tb_fire_control;

  localparam int AMMO_W    = 9;
  localparam int COOLDOWN  = 8;
  localparam int BURST_LEN = 3;
  localparam logic [3:0] ATTACK = 4'b0010;

  logic              clk;
  logic              rst;
  logic [3:0]        mode;
  logic              trigger;
  logic              burst_sel;
  logic [AMMO_W-1:0] ammo;
  logic [AMMO_W-1:0] rate;
  logic              fire;
  logic [AMMO_W-1:0] fire_rate;
  logic              busy;
  logic              error;
  logic [7:0]        shots_fired;

  fire_control #(
    .AMMO_W    (AMMO_W),
    .COOLDOWN  (COOLDOWN),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .trigger     (trigger),
    .burst_sel   (burst_sel),
    .ammo        (ammo),
    .rate        (rate),
    .fire        (fire),
    .fire_rate   (fire_rate),
    .busy        (busy),
    .error       (error),
    .shots_fired (shots_fired)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counters and scoreboard
  int n_vec  = 0;
  int n_fail = 0;
  logic [AMMO_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: time-based view of the sequencer. Each accepted shot
  // reserves the next COOLDOWN+1 cycles; bursts re-check legality on the
  // last reserved cycle.
  int                cyc;
  int                idle_at;
  int                check_at;
  int                rem;
  bit                prev_trig;
  logic [AMMO_W-1:0] m_rate;
  logic [7:0]        m_shots;
  bit                e_fire, e_err;
  bit                wpn_en;

  task automatic model_reset();
    idle_at   = 0;
    check_at  = -1;
    rem       = 0;
    prev_trig = 1'b1;
    m_rate    = '0;
    m_shots   = 8'd0;
    exp_q.delete();
  endtask

  task automatic predict();
    bit                pr, lg, burst;
    logic [AMMO_W-1:0] eff;
    e_fire = 1'b0;
    e_err  = 1'b0;
    pr  = trigger && !prev_trig;
    eff = (rate == 0) ? AMMO_W'(1) : rate;
    lg  = (mode == ATTACK) && (ammo != 0) && (ammo >= eff);
`ifdef FIRE_CONTROL_BURST_EN
    burst = burst_sel;
`else
    burst = 1'b0;
`endif
    if (cyc >= idle_at) begin
      if (pr) begin
        if (lg) begin
          e_fire   = 1'b1;
          m_rate   = eff;
          rem      = burst ? BURST_LEN - 1 : 0;
          idle_at  = cyc + COOLDOWN + 2;
          check_at = cyc + COOLDOWN + 1;
        end else begin
          e_err = 1'b1;
        end
      end
    end else if (rem > 0 && cyc == check_at) begin
      if (lg) begin
        e_fire   = 1'b1;
        rem      = rem - 1;
        idle_at  = cyc + COOLDOWN + 2;
        check_at = cyc + COOLDOWN + 1;
      end else begin
        e_err = (mode == ATTACK);
        rem   = 0;
      end
    end
    prev_trig = trigger;
    if (e_fire) exp_q.push_back(m_rate);
  endtask

  // driver: one clock cycle with the currently driven inputs
  task automatic step();
    predict();
    @(posedge clk);
    @(negedge clk);
    check("fire", 32'(fire), 32'(e_fire));
    check("error", 32'(error), 32'(e_err));
    check("busy", 32'(busy), 32'(cyc + 1 < idle_at));
    check("fire_rate", 32'(fire_rate), 32'(m_rate));
    check("shots_fired", 32'(shots_fired), 32'(m_shots));
    if (fire) begin
      if (exp_q.size() != 0) check("shot_rate", 32'(fire_rate), 32'(exp_q.pop_front()));
      else                   check("unexpected_shot", 32'(fire), 32'd0);
    end
    if (e_fire) begin
      m_shots = m_shots + 8'd1;
      if (wpn_en) ammo = (ammo > m_rate) ? ammo - m_rate : '0;
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_press(input int hold, input int tail);
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    run(hold);
    trigger = 1'b0;
    run(tail);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fire"}, 32'(fire), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_fire_rate"}, 32'(fire_rate), 32'd0);
    check({tag, "_shots"}, 32'(shots_fired), 32'd0);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; mode = 4'd0; trigger = 1'b0; burst_sel = 1'b0;
    ammo = '0; rate = '0; wpn_en = 1'b0; cyc = 0;
    model_reset();
    apply_reset(2);

    // single shot in attack mode
    mode = ATTACK; ammo = 9'd100; rate = 9'd5;
    do_press(3, 12);
    check("single_shots", 32'(shots_fired), 32'd1);
    check("single_rate", 32'(fire_rate), 32'd5);

    // wrong mode: rejected
    mode = 4'b0001;
    do_press(2, 3);
    check("mode_rej_shots", 32'(shots_fired), 32'd1);

    // insufficient ammo, then rate 0 treated as 1
    mode = ATTACK; ammo = 9'd4; rate = 9'd5;
    do_press(2, 3);
    ammo = 9'd1; rate = 9'd0;
    do_press(2, 12);
    check("rate0_rate", 32'(fire_rate), 32'd1);

    // burst with weapons stage subtracting; repress during COOL ignored
    wpn_en = 1'b1; burst_sel = 1'b1; ammo = 9'd100; rate = 9'd10;
    do_press(2, 4);
    do_press(2, 30);
    // burst running dry after the first shot
    ammo = 9'd15;
    do_press(1, 30);
    burst_sel = 1'b0;

    // trigger held across reset release never fires
    trigger = 1'b1; ammo = 9'd100; rate = 9'd3;
    apply_reset(2);
    run(6);
    check("held_shots", 32'(shots_fired), 32'd0);
    trigger = 1'b0;
    run(2);

    // reset mid-cooldown aborts at once
    burst_sel = 1'b1;
    do_press(1, 4);
    apply_reset(1);
    run(3);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) trigger = ~trigger;
      if ($urandom_range(0, 15) == 0) mode = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : ATTACK;
      if ($urandom_range(0, 7) == 0) rate = 9'($urandom_range(0, 12));
      if ($urandom_range(0, 40) == 0) ammo = 9'($urandom_range(0, 60));
      burst_sel = 1'($urandom_range(0, 1));
      step();
    end
    trigger = 1'b0;
    run(40);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fire_control.md
# fire_control

Trigger-to-weapon sequencer that sits directly upstream of the weapons stage. It turns the pilot's level trigger into single-cycle `fire` strobes plus a latched per-shot `fire_rate`, enforcing attack-mode gating, an ammo-sufficiency check against the weapons stage's current count, and a minimum cooldown between shots. It optionally sequences fixed-length bursts from one trigger press.

## Interface
Parameters:
- AMMO_W, 9, width of ammo count and rate; matches weapons stage.
- COOLDOWN, 8, cycles from one `fire` strobe to the earliest next strobe; legal range 2..255.
- BURST_LEN, 3, shots per burst; legal range 2..15; used only with burst support.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  4  ship mode; attack mode is 4'b0010.
- trigger  in  1  level trigger from the pilot console.
- burst_sel  in  1  1 = burst, 0 = single shot; sampled only on an accepted press.
- ammo  in  AMMO_W  current ammo count, driven by the weapons stage output.
- rate  in  AMMO_W  requested rounds per shot.
- fire  out  1  one-cycle shot strobe; drives the weapons `fire` input.
- fire_rate  out  AMMO_W  rounds per shot; drives the weapons `fireRate` input. Stable from the `fire` cycle until the next accepted press.
- busy  out  1  high in SHOOT or COOL.
- error  out  1  one-cycle pulse on a rejected press or an aborted burst.
- shots_fired  out  8  total shots issued.

## Operation
- Press detect: `press = trigger & ~trig_q`. `trig_q` resets to 1, so a trigger held through reset release does not fire.
- Effective rate: `eff_rate = (rate == 0) ? 1 : rate`.
- Shot is legal when `mode == 4'b0010` and `ammo != 0` and `ammo >= eff_rate`. The compare is unsigned at AMMO_W bits.
- State machine:
  - IDLE:
    - On a press with a legal shot: go to SHOOT, latch `fire_rate = eff_rate`, load `remaining = BURST_LEN - 1` if `burst_sel`, else 0.
    - On a press without a legal shot: pulse `error` and stay in IDLE.
  - SHOOT (exactly 1 cycle): `fire = 1`, `shots_fired` increments and wraps 255->0, then go to COOL and load the cooldown counter with COOLDOWN-1.
  - COOL: count down. At 0:
    - If `remaining != 0`, the shot is legal and `mode` is attack: decrement `remaining` and go to SHOOT. `fire_rate` is not re-latched.
    - If `remaining != 0` and the mode left attack: clear `remaining` and go to IDLE, with no error.
    - If `remaining != 0` and ammo is insufficient: clear `remaining`, pulse `error`, go to IDLE.
    - If `remaining == 0`: go to IDLE.
- Presses during SHOOT or COOL are ignored: no queueing, no error.
- A `rate` change after the press affects only the next press.
- `rst` asserted mid-burst aborts immediately, with no `fire` and no `error`.

## Timing
- Reset values: `fire=0`, `fire_rate=0`, `busy=0`, `error=0`, `shots_fired=0`, state IDLE, `remaining=0`, `trig_q=1`.
- Press at cycle n (trigger low at n-1, high at n) gives `fire` high at cycle n+1.
- The rejection `error` pulse is at cycle n+1.
- Shot-to-shot spacing is exactly COOLDOWN+1 cycles: SHOOT, then COOLDOWN cycles of COOL.
- `busy` falls the cycle after the last COOL cycle.
- The weapons stage updates `ammo` one cycle after `fire`, so a COOLDOWN of at least 2 guarantees the burst legality check sees the post-shot count.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `FIRE_CONTROL_BURST_EN`
  - Defined: `burst_sel` and BURST_LEN are honoured as above.
  - Undefined: `burst_sel` is ignored, `remaining` is always 0, the `remaining` register and its logic are removed, and every press yields at most one shot.

## Structure
- Shared package `weapons_pkg`:
  - mode encoding constant `MODE_ATTACK = 4'b0010`;
  - state typedef `fc_state_t {FC_IDLE, FC_SHOOT, FC_COOL}`;
  - `AMMO_W` default.
- One sub-module, `cooldown_timer`: an 8-bit load/decrement counter with a `done` flag, instantiated once.
- Everything else lives in the `fire_control` top.

## Test plan
- Reset, then trigger rises with mode=0010, ammo=100, rate=5 -> `fire` at press+1, `fire_rate=5`, `shots_fired=1`, `busy` high for 1+8 cycles.
- Same setup but mode=0001 -> no `fire`, `error` pulses at press+1, `shots_fired` stays 0.
- mode=0010, ammo=4, rate=5 -> rejected with an `error` pulse. Repeat with rate=0 and ammo=1 -> fires with `fire_rate=1`.
- Burst build, `burst_sel=1`, ammo=100, rate=10, weapons model subtracting -> 3 `fire` strobes spaced 9 cycles apart, `shots_fired=3`. A second press during COOL is ignored.
- Burst with ammo=15, rate=10 -> first shot fires, ammo becomes 5, burst aborts at the end of COOL with an `error` pulse, then IDLE.
- Trigger held high across reset release -> no `fire`. Separately, `rst` asserted mid-COOL -> all outputs 0 immediately, state IDLE.
